timer_periph: RTL and testbench
===============================

Name: timer_periph

Overview:
- Memory-mapped peripheral responder at base 0x40000000 on the CPU data bus.
- Answers the loads and stores that the boot and interrupt program issues.
- Provides the reload timer (TH/TL/TCON) that drives the CPU interrupt line, plus the LED, switch and 7-segment digit registers.
- Sits beside data memory behind the CPU address decoder; read data is muxed into the load path.

Parameters:
- BASE_ADDR, 32'h40000000, base of the register window; decoded on addr[31:6].
- LED_W, 8, width of the LED register and led output.
- SW_W, 8, width of the switch input.
- DIGI_W, 12, width of the digit register: {4 anode-select bits, 8 segment bits}.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- rd  in  1  read strobe.
- wr  in  1  write strobe; sampled at posedge clk.
- addr  in  32  byte address; word aligned, addr[1:0] ignored.
- wdata  in  32  write data.
- rdata  out  32  read data; combinational.
- led  out  LED_W  LED register.
- switch  in  SW_W  board switches.
- digi  out  DIGI_W  7-segment anode-select and segment drive.
- irqout  out  1  interrupt request to CPU; level-sensitive.

Behaviour:
Register map (offset from BASE_ADDR):
- 0x00 TH: 32-bit reload value.
- 0x04 TL: 32-bit counter.
- 0x08 TCON: bits [2:0], upper bits read as 0.
  - [0] enable.
  - [1] interrupt enable.
  - [2] interrupt status.
- 0x0C LED: read/write.
- 0x10 SWITCH: read-only; writes ignored.
- 0x14 DIGI: read/write.
- Unmapped offsets in the window read 0; writes to them are ignored.
- Addresses outside the window: no effect; rdata=0.

Reset (async, reset==0):
- TH=0, TL=0, TCON=0, LED=0, DIGI=0.
- irqout=0.
- rdata follows the reset register values.

Read path:
- rdata is valid the same cycle as rd && in-window; no wait states.
- rd=0 gives rdata=0.
- Narrow registers are zero-extended.

Write path:
- On posedge clk with wr && in-window, the addressed register takes wdata, truncated to the register width.

Timer, evaluated each posedge clk when TCON[0]=1:
- TL != 32'hFFFFFFFF: TL <= TL+1.
- TL == 32'hFFFFFFFF (overflow): TL <= TH; if TCON[1]=1, TCON[2] <= 1.
- TCON[0]=0: TL holds.
- irqout = TCON[2] & TCON[1], combinational from the registers.

Simultaneous events:
- CPU write to TL in the same cycle as an increment or reload: the write wins.
- CPU write to TCON in the same cycle as an overflow that sets status:
  - TCON[1:0] <= wdata[1:0].
  - TCON[2] <= wdata[2] | 1.
  - A pending interrupt is never lost to the ISR's read-modify-write.
- CPU write to TH in the same cycle as a reload: TL reloads the old TH; TH takes the new value.

Other boundaries:
- Software clears status by writing TCON[2]=0; the hardware never clears it.
- TH=32'hFFFFFFFF with enable=1: overflow occurs every cycle.
- Reset asserted mid-count: all state clears immediately, with no dependence on clk.

Decomposition:
- Shared package holds:
  - register offset constants: TH_OFS, TL_OFS, TCON_OFS, LED_OFS, SW_OFS, DIGI_OFS;
  - TCON bit indices: TCON_EN, TCON_IE, TCON_IS.
- One sub-module, reload_timer: owns TH, TL and TCON, the overflow logic and the write-vs-overflow merge.
- The top level owns address decode, the LED/DIGI registers and the rdata mux.

Test Plan:
- Reset: assert reset=0 mid-run with TL=5 and TCON=3 -> all registers, rdata and irqout are 0 with no clock edge; they stay 0 for 3 cycles after release.
- Reload count: write TH=0xFFFFFFFC, TL=0xFFFFFFFE, TCON=3 -> TL reads FFFFFFFF, then FFFFFFFC.
  - TCON reads 7; irqout=1 on the cycle after the overflow edge.
  - TL then continues FFFFFFFD.
- ISR sequence: with status set, read TCON=7; write 7 & 0xFFFFFFF9 = 1 -> irqout=0. Write TCON=3 -> irqout stays 0 until the next overflow.
- Collision: time a TCON write of 0x1 to land on the overflow edge -> TCON reads 0x5 and irqout=0 (IE cleared). A following write of 0x7 gives irqout=1.
- Disabled counting: TCON=0 with TL=0x10 for 20 cycles -> TL stays 0x10; overflow with TCON=1 (IE off) reloads TL and leaves TCON[2]=0.
- Misc registers:
  - write LED=0x1A5 -> led=0xA5 and reads 0xA5;
  - DIGI=0xF7E -> digi=0xF7E;
  - switch=0x3C -> read 0x10 gives 0x3C, and a write to 0x10 changes nothing;
  - read 0x18 gives 0;
  - read with rd=0 gives 0.

Source files
------------

// File: rtl/timer_periph_pkg.sv
// timer_periph_pkg
//   Shared definitions for the timer/LED/switch/digit peripheral:
//   register byte offsets inside the 64-byte window, TCON bit positions,
//   the register-select enum and a helper that maps an offset to a select.
//   No ports (package).
package timer_periph_pkg;

  // Byte offsets of each register inside the peripheral window
  localparam logic [5:0] TH_OFS   = 6'h00;
  localparam logic [5:0] TL_OFS   = 6'h04;
  localparam logic [5:0] TCON_OFS = 6'h08;
  localparam logic [5:0] LED_OFS  = 6'h0C;
  localparam logic [5:0] SW_OFS   = 6'h10;
  localparam logic [5:0] DIGI_OFS = 6'h14;

  // TCON bit positions: enable, interrupt enable, interrupt status
  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_IS = 2;
  localparam int TCON_W  = 3;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_TH,
    SEL_TL,
    SEL_TCON,
    SEL_LED,
    SEL_SW,
    SEL_DIGI
  } regSelT;

  // Word-aligned offset to register select; unmapped offsets give SEL_NONE
  function automatic regSelT decodeOffset(input logic [5:0] ofs);
    regSelT sel;
    case (ofs)
      TH_OFS:   sel = SEL_TH;
      TL_OFS:   sel = SEL_TL;
      TCON_OFS: sel = SEL_TCON;
      LED_OFS:  sel = SEL_LED;
      SW_OFS:   sel = SEL_SW;
      DIGI_OFS: sel = SEL_DIGI;
      default:  sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/timer_periph_reload_timer.sv
// reload_timer
//   Owns TH (reload value), TL (counter) and TCON (enable / interrupt
//   enable / interrupt status). TL counts up while enabled and reloads
//   from TH when it passes all-ones; an overflow with interrupts enabled
//   sets the status bit, which only software can clear.
// Ports:
//   i_clk, i_rstN          clock, asynchronous active-low reset
//   i_wrTh/i_wrTl/i_wrTcon per-register CPU write strobes
//   i_wdata                CPU write data
//   o_th, o_tl, o_tcon     register contents for the read mux
//   o_irq                  level interrupt request (status & enable)
module reload_timer (
  input  logic        i_clk,
  input  logic        i_rstN,
  input  logic        i_wrTh,
  input  logic        i_wrTl,
  input  logic        i_wrTcon,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_th,
  output logic [31:0] o_tl,
  output logic [2:0]  o_tcon,
  output logic        o_irq
);
  import timer_periph_pkg::*;

  logic [31:0] r_th;
  logic [31:0] r_tl;
  logic [2:0]  r_tcon;
  logic        w_overflow;
  logic        w_setStatus;

  // Overflow and status-set are judged on the register values before the
  // edge, so a same-cycle CPU write never changes whether this edge reloads.
  assign w_overflow  = r_tcon[TCON_EN] && (r_tl == 32'hFFFF_FFFF);
  assign w_setStatus = w_overflow && r_tcon[TCON_IE];

  // TH only changes on a CPU write; a reload on the same edge still sees
  // the old value because of non-blocking update.
  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN) begin
      r_th <= '0;
    end else if (i_wrTh) begin
      r_th <= i_wdata;
    end
  end

  // A CPU write to TL takes priority over counting and reloading.
  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN) begin
      r_tl <= '0;
    end else if (i_wrTl) begin
      r_tl <= i_wdata;
    end else if (r_tcon[TCON_EN]) begin
      r_tl <= w_overflow ? r_th : r_tl + 32'd1;
    end
  end

  // The status bit is ORed into a colliding CPU write so an ISR
  // read-modify-write can never swallow a freshly raised interrupt.
  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN) begin
      r_tcon <= '0;
    end else if (i_wrTcon) begin
      r_tcon <= i_wdata[TCON_W-1:0] | {w_setStatus, 2'b00};
    end else if (w_setStatus) begin
      r_tcon[TCON_IS] <= 1'b1;
    end
  end

  assign o_th   = r_th;
  assign o_tl   = r_tl;
  assign o_tcon = r_tcon;
  assign o_irq  = r_tcon[TCON_IS] & r_tcon[TCON_IE];

endmodule

// File: rtl/timer_periph.sv
// timer_periph
//   Memory-mapped peripheral on the CPU data bus: reload timer with
//   interrupt, LED register, switch input and 7-segment digit register.
// Ports:
//   clk, reset   clock, asynchronous active-low reset
//   rd, wr       read / write strobes
//   addr, wdata  byte address (addr[1:0] ignored), write data
//   rdata        combinational read data, 0 when not selected
//   led, digi    LED and digit register outputs
//   switch       board switch input
//   irqout       level interrupt request to the CPU
module timer_periph #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          LED_W     = 8,
  parameter int          SW_W      = 8,
  parameter int          DIGI_W    = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd,
  input  logic              wr,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic [LED_W-1:0]  led,
  input  logic [SW_W-1:0]   switch,
  output logic [DIGI_W-1:0] digi,
  output logic              irqout
);
  import timer_periph_pkg::*;

  logic              w_inWindow;
  regSelT            w_sel;
  logic [31:0]       w_th;
  logic [31:0]       w_tl;
  logic [2:0]        w_tcon;
  logic              w_irq;
  logic [LED_W-1:0]  r_led;
  logic [DIGI_W-1:0] r_digi;
  logic              w_unused;

  // The window is 64 bytes, so addr[31:6] picks the block and addr[5:2]
  // the word; byte lane bits are deliberately ignored.
  assign w_inWindow = (addr[31:6] == BASE_ADDR[31:6]);
  assign w_sel      = w_inWindow ? decodeOffset({addr[5:2], 2'b00}) : SEL_NONE;
  assign w_unused   = &{1'b0, addr[1:0]};

  reload_timer u_timer (
    .i_clk    (clk),
    .i_rstN   (reset),
    .i_wrTh   (wr && (w_sel == SEL_TH)),
    .i_wrTl   (wr && (w_sel == SEL_TL)),
    .i_wrTcon (wr && (w_sel == SEL_TCON)),
    .i_wdata  (wdata),
    .o_th     (w_th),
    .o_tl     (w_tl),
    .o_tcon   (w_tcon),
    .o_irq    (w_irq)
  );

  // LED and digit registers keep only the low bits of the written word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_led  <= '0;
      r_digi <= '0;
    end else if (wr) begin
      if (w_sel == SEL_LED)  r_led  <= wdata[LED_W-1:0];
      if (w_sel == SEL_DIGI) r_digi <= wdata[DIGI_W-1:0];
    end
  end

  // Read mux: narrow registers zero-extend, anything unselected reads 0.
  always_comb begin
    rdata = '0;
    if (rd) begin
      case (w_sel)
        SEL_TH:   rdata = w_th;
        SEL_TL:   rdata = w_tl;
        SEL_TCON: rdata[TCON_W-1:0] = w_tcon;
        SEL_LED:  rdata[LED_W-1:0]  = r_led;
        SEL_SW:   rdata[SW_W-1:0]   = switch;
        SEL_DIGI: rdata[DIGI_W-1:0] = r_digi;
        default:  rdata = '0;
      endcase
    end
  end

  assign led    = r_led;
  assign digi   = r_digi;
  assign irqout = w_irq;

endmodule

// File: tb/tb_timer_periph.sv
// tb_timer_periph
//   Self-checking bench for timer_periph. Expected values are pushed onto
//   a scoreboard queue as each stimulus/observation is set up and popped
//   when the DUT output is sampled.
module tb_timer_periph;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [31:0] A_TH   = BASE + 32'h00;
  localparam logic [31:0] A_TL   = BASE + 32'h04;
  localparam logic [31:0] A_TCON = BASE + 32'h08;
  localparam logic [31:0] A_LED  = BASE + 32'h0C;
  localparam logic [31:0] A_SW   = BASE + 32'h10;
  localparam logic [31:0] A_DIGI = BASE + 32'h14;
  localparam logic [31:0] A_HOLE = BASE + 32'h18;

  logic        clk;
  logic        reset;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  led;
  logic [7:0]  switch;
  logic [11:0] digi;
  logic        irqout;

  typedef struct {
    string       tag;
    logic [31:0] value;
  } expT;

  expT sbQ[$];
  int  checks = 0;
  int  passes = 0;

  timer_periph #(
    .BASE_ADDR (BASE),
    .LED_W     (8),
    .SW_W      (8),
    .DIGI_W    (12)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .rd     (rd),
    .wr     (wr),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .led    (led),
    .switch (switch),
    .digi   (digi),
    .irqout (irqout)
  );

  // 20 ns clock; posedges at 10, 30, 50, ...
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic expectPush(input string tag, input logic [31:0] value);
    expT e;
    e.tag   = tag;
    e.value = value;
    sbQ.push_back(e);
  endtask

  task automatic checkNext(input logic [31:0] observed);
    expT e;
    if (sbQ.size() == 0) begin
      checkOutput("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sbQ.pop_front();
      checkOutput(e.tag, observed, e.value);
    end
  endtask

  // One bus write, committed on the next rising edge; returns 1 ns after it
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    wr    = 1'b1;
    addr  = a;
    wdata = d;
    @(posedge clk);
    #1;
    wr    = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic readCheck(input string tag, input logic [31:0] a,
                           input logic [31:0] expected);
    expectPush(tag, expected);
    rd   = 1'b1;
    addr = a;
    #1;
    checkNext(rdata);
    rd   = 1'b0;
  endtask

  task automatic irqCheck(input string tag, input logic expected);
    expectPush(tag, {31'b0, expected});
    #1;
    checkNext({31'b0, irqout});
  endtask

  task automatic ledCheck(input string tag, input logic [7:0] expected);
    expectPush(tag, {24'b0, expected});
    #1;
    checkNext({24'b0, led});
  endtask

  task automatic digiCheck(input string tag, input logic [11:0] expected);
    expectPush(tag, {20'b0, expected});
    #1;
    checkNext({20'b0, digi});
  endtask

  initial begin
    reset  = 1'b0;
    rd     = 1'b0;
    wr     = 1'b0;
    addr   = '0;
    wdata  = '0;
    switch = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    tick(1);
    readCheck("init_tl", A_TL, 32'h0);

    // Reset asserted mid-count clears everything without a clock edge
    applyStimulus(A_LED, 32'h55);
    applyStimulus(A_TH, 32'h1234);
    applyStimulus(A_TL, 32'h5);
    applyStimulus(A_TCON, 32'h3);
    #3;
    reset = 1'b0;
    readCheck("rst_th", A_TH, 32'h0);
    readCheck("rst_tl", A_TL, 32'h0);
    readCheck("rst_tcon", A_TCON, 32'h0);
    ledCheck("rst_led", 8'h00);
    irqCheck("rst_irq", 1'b0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      readCheck("post_rst_tl", A_TL, 32'h0);
    end

    // Reload count with interrupt
    applyStimulus(A_TH, 32'hFFFF_FFFC);
    applyStimulus(A_TL, 32'hFFFF_FFFE);
    applyStimulus(A_TCON, 32'h3);
    readCheck("rl_tl0", A_TL, 32'hFFFF_FFFE);
    tick(1);
    readCheck("rl_tl1", A_TL, 32'hFFFF_FFFF);
    irqCheck("rl_irq_pre", 1'b0);
    tick(1);
    readCheck("rl_tl_reload", A_TL, 32'hFFFF_FFFC);
    readCheck("rl_tcon", A_TCON, 32'h7);
    irqCheck("rl_irq", 1'b1);
    tick(1);
    readCheck("rl_tl_cont", A_TL, 32'hFFFF_FFFD);

    // ISR read-modify-write clears status
    readCheck("isr_tcon_rd", A_TCON, 32'h7);
    applyStimulus(A_TCON, 32'h7 & 32'hFFFF_FFF9);
    irqCheck("isr_irq_clr", 1'b0);
    readCheck("isr_tcon", A_TCON, 32'h1);
    applyStimulus(A_TCON, 32'h3);
    irqCheck("isr_irq_wait", 1'b0);
    readCheck("isr_tl", A_TL, 32'hFFFF_FFFF);
    tick(1);
    irqCheck("isr_irq_next", 1'b1);

    // TCON write colliding with a status-setting overflow
    applyStimulus(A_TCON, 32'h3);
    applyStimulus(A_TL, 32'hFFFF_FFFF);
    readCheck("tl_write_wins", A_TL, 32'hFFFF_FFFF);
    applyStimulus(A_TCON, 32'h1);
    readCheck("col_tcon", A_TCON, 32'h5);
    irqCheck("col_irq", 1'b0);
    readCheck("col_tl", A_TL, 32'hFFFF_FFFC);
    applyStimulus(A_TCON, 32'h7);
    irqCheck("col_irq_on", 1'b1);

    // TH write on the reload edge: TL takes the old TH
    applyStimulus(A_TL, 32'hFFFF_FFFF);
    applyStimulus(A_TH, 32'h100);
    readCheck("thcol_tl", A_TL, 32'hFFFF_FFFC);
    readCheck("thcol_th", A_TH, 32'h100);

    // TH all-ones: overflow on every edge
    applyStimulus(A_TH, 32'hFFFF_FFFF);
    applyStimulus(A_TL, 32'hFFFF_FFFF);
    for (int i = 0; i < 2; i++) begin
      tick(1);
      readCheck("thmax_tl", A_TL, 32'hFFFF_FFFF);
    end

    // Disabled counter holds; overflow with IE off leaves status clear
    applyStimulus(A_TCON, 32'h0);
    applyStimulus(A_TL, 32'h10);
    tick(20);
    readCheck("dis_tl", A_TL, 32'h10);
    applyStimulus(A_TH, 32'h20);
    applyStimulus(A_TL, 32'hFFFF_FFFF);
    applyStimulus(A_TCON, 32'h1);
    tick(1);
    readCheck("noie_tl", A_TL, 32'h20);
    readCheck("noie_tcon", A_TCON, 32'h1);
    irqCheck("noie_irq", 1'b0);
    applyStimulus(A_TCON, 32'hFFFF_FFF8);
    readCheck("tcon_upper", A_TCON, 32'h0);

    // Misc registers, window decode and rd gating
    applyStimulus(A_LED, 32'h1A5);
    ledCheck("led_out", 8'hA5);
    readCheck("led_rd", A_LED, 32'hA5);
    applyStimulus(A_DIGI, 32'hF7E);
    digiCheck("digi_out", 12'hF7E);
    readCheck("digi_rd", A_DIGI, 32'hF7E);
    switch = 8'h3C;
    readCheck("sw_rd", A_SW, 32'h3C);
    applyStimulus(A_SW, 32'hFF);
    readCheck("sw_ro", A_SW, 32'h3C);
    ledCheck("sw_wr_led", 8'hA5);
    readCheck("hole_rd", A_HOLE, 32'h0);
    readCheck("outside_rd", 32'h5000_000C, 32'h0);
    applyStimulus(32'h5000_000C, 32'h11);
    ledCheck("outside_wr", 8'hA5);
    expectPush("rd_low", 32'h0);
    rd   = 1'b0;
    addr = A_LED;
    #1;
    checkNext(rdata);

    if (sbQ.size() != 0) begin
      checkOutput("scoreboard_left", sbQ.size(), 32'd0);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
